ex_stage_unit: RTL and testbench
================================

Name: ex_stage_unit

Overview:
- Execute stage sitting directly downstream of the decode/execute pipeline register.
- Consumes the registered decode bundle: operands, sign-extended immediate, register specifiers and control bits.
- Single-cycle ALU ops complete in one cycle. MUL runs a 32-iteration shift-add sequencer and asserts stall back to decode while busy.
- Results and the remaining control bits go into a registered execute/memory bundle.

Parameters:
- DATA_W, 32, operand/result width.
- MUL_ITER, 32, multiply iterations. Must equal DATA_W.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  decode bundle holds a live instruction.
- RegData1In  input  32  rs operand.
- RegData2In  input  32  rt operand / store data.
- ExtendidoIn  input  32  sign-extended immediate.
- rtIn  input  5  rt specifier.
- rdIn  input  5  rd specifier.
- ALUControlIn  input  6  operation code.
- ALUSrcIn, RegWriteIn, MemtoRegIn, MemWriteIn, RegDstIn, BranchIn  input  1 each  control bits.
- flush  input  1  kill the instruction currently in execute.
- stall  output  1  decode must hold its bundle and not advance.
- out_valid  output  1  execute/memory bundle is live.
- AluResultOut  output  32  result.
- WriteDataOut  output  32  store data (rt operand).
- WriteRegOut  output  5  destination: rdIn if RegDstIn=1, else rtIn.
- ZeroOut  output  1  result == 0.
- RegWriteOut, MemtoRegOut, MemWriteOut, BranchOut  output  1 each  forwarded control.

Behaviour:
- Reset:
  - Asynchronous, active-low; one clock domain (clk), no synchronous reset.
  - State=IDLE, counter=0.
  - All outputs 0: out_valid, stall, AluResultOut, WriteDataOut, WriteRegOut, ZeroOut and all control outputs.
  - Reset mid-MUL discards the operation.
- Operand B = ALUSrcIn ? ExtendidoIn : RegData2In.
- Op codes (shared package): ADD 6'h20, SUB 6'h22, AND 6'h24, OR 6'h25, XOR 6'h26, SLT 6'h2A (signed compare, result 1/0), MUL 6'h18.
  - Unknown codes produce result 0 with control bits still forwarded.
  - ADD/SUB wrap modulo 2^32; no overflow trap.
- State IDLE:
  - in_valid=1, non-MUL op: on the next edge the output bundle registers the result and out_valid=1. Latency 1 cycle.
  - in_valid=1, op=MUL: latch A, B and the control bits; counter=0; go to MUL. stall rises combinationally in this same cycle.
  - in_valid=0: out_valid=0 on the next edge; other outputs hold.
- State MUL:
  - Each cycle: if B[0], acc += A. Then A <<= 1, B >>= 1, counter++.
  - Result is the low 32 bits of the unsigned product, which equals the signed low word.
  - stall=1 throughout MUL. out_valid=0 throughout.
  - When counter==MUL_ITER-1, the next edge writes acc to AluResultOut, sets out_valid=1 and returns to IDLE. stall is 0 in the following cycle.
  - Total latency 32 cycles from the accept edge to out_valid. Decode holds its next instruction until stall falls.
- flush:
  - flush=1 in IDLE: the incoming instruction is dropped; out_valid=0 on the next edge.
  - flush=1 in MUL: abort to IDLE, out_valid=0, stall drops the next cycle.
  - flush and completion in the same cycle: flush wins and no result is written.
- Downstream has no backpressure; out_valid is a one-cycle pulse per instruction.
- ZeroOut is derived from the registered result value. It is valid whenever out_valid=1.

Decomposition:
- Package ex_pkg: op-code localparams (OP_ADD…OP_MUL), state encoding (ST_IDLE, ST_MUL), DATA_W.
- One sub-module, ex_mul_seq: the shift-add sequencer with start/done/abort signals and a 32-bit product output.
- ALU, operand mux and output register stay in ex_stage_unit.

Test Plan:
- Reset: assert rst_n=0 mid-stream -> all outputs 0 immediately, without waiting for a clock; after release, out_valid stays 0 until in_valid.
- ADD, ALUSrc=0: A=32'h7FFF_FFFF, B=1 -> one cycle later AluResultOut=32'h8000_0000, ZeroOut=0, out_valid pulse; then SUB A=5, B=5 -> result 0, ZeroOut=1.
- SLT and immediate: A=32'hFFFF_FFFF, Ext=2, ALUSrc=1 -> result 1. Check WriteRegOut=rt when RegDst=0 and rd when RegDst=1.
- MUL: A=12345, B=32'hFFFF_FFFF -> stall high 32 cycles, then AluResultOut=32'hFFFF_CFC7 (−12345), out_valid 1 cycle. A second op held on the inputs issues the cycle after stall falls.
- Flush: MUL started, flush at iteration 10 -> no out_valid, stall low next cycle, next ADD completes normally. Flush coincident with the final iteration -> no result.
- Back-to-back: 4 consecutive single-cycle ops with in_valid=1 -> 4 consecutive out_valid cycles with correct results and control pass-through; stall never asserted.

Source files
------------

// File: rtl/ex_pkg.sv
// Shared definitions for the execute stage: op codes, FSM encoding, widths.
package ex_pkg;

   localparam int DATA_W = 32;

   localparam logic [5:0] OP_ADD = 6'h20;
   localparam logic [5:0] OP_SUB = 6'h22;
   localparam logic [5:0] OP_AND = 6'h24;
   localparam logic [5:0] OP_OR  = 6'h25;
   localparam logic [5:0] OP_XOR = 6'h26;
   localparam logic [5:0] OP_SLT = 6'h2A;
   localparam logic [5:0] OP_MUL = 6'h18;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_MUL  = 1'b1
   } state_t;

   // Control bits that travel with an instruction into the execute/memory bundle
   typedef struct packed {
      logic       reg_write;
      logic       memto_reg;
      logic       mem_write;
      logic       branch;
      logic [4:0] write_reg;
   } ctrl_t;

endpackage

// File: rtl/ex_mul_seq.sv
// Shift-add multiplier: one partial product per cycle, low DATA_W bits kept.
module ex_mul_seq #(
   parameter int DATA_W   = 32,
   parameter int MUL_ITER = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   input  logic [DATA_W-1:0] a_in,
   input  logic [DATA_W-1:0] b_in,
   output logic              done,
   output logic [DATA_W-1:0] product
);

   localparam int CW = $clog2(MUL_ITER);

   logic [DATA_W-1:0] a, b, acc;
   logic [CW-1:0]     cnt;
   logic              busy;

   // The accumulator value after this cycle's step; on the final step it is the product
   assign product = acc + (b[0] ? a : '0);
   assign done    = busy && (cnt == CW'(MUL_ITER - 1));

   // Iterate while busy; abort and reset discard the operation
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a    <= '0;
         b    <= '0;
         acc  <= '0;
         cnt  <= '0;
         busy <= 1'b0;
      end else if (abort) begin
         cnt  <= '0;
         busy <= 1'b0;
      end else if (start) begin
         a    <= a_in;
         b    <= b_in;
         acc  <= '0;
         cnt  <= '0;
         busy <= 1'b1;
      end else if (busy) begin
         acc <= product;
         a   <= a << 1;
         b   <= b >> 1;
         cnt <= cnt + CW'(1);
         if (done) busy <= 1'b0;
      end
   end

endmodule

// File: rtl/ex_stage_unit.sv
// Execute stage: operand mux, single-cycle ALU, multi-cycle MUL, EX/MEM register.
module ex_stage_unit #(
   parameter int DATA_W   = ex_pkg::DATA_W,
   parameter int MUL_ITER = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] RegData1In,
   input  logic [DATA_W-1:0] RegData2In,
   input  logic [DATA_W-1:0] ExtendidoIn,
   input  logic [4:0]        rtIn,
   input  logic [4:0]        rdIn,
   input  logic [5:0]        ALUControlIn,
   input  logic              ALUSrcIn,
   input  logic              RegWriteIn,
   input  logic              MemtoRegIn,
   input  logic              MemWriteIn,
   input  logic              RegDstIn,
   input  logic              BranchIn,
   input  logic              flush,
   output logic              stall,
   output logic              out_valid,
   output logic [DATA_W-1:0] AluResultOut,
   output logic [DATA_W-1:0] WriteDataOut,
   output logic [4:0]        WriteRegOut,
   output logic              ZeroOut,
   output logic              RegWriteOut,
   output logic              MemtoRegOut,
   output logic              MemWriteOut,
   output logic              BranchOut
);

   import ex_pkg::*;

   state_t            state, state_nxt;
   logic [DATA_W-1:0] op_b, alu_res, mul_prod;
   logic              is_mul, mul_start, mul_abort, mul_done, alu_accept;
   ctrl_t             ctrl_in, ctrl_mul;
   logic [DATA_W-1:0] wdata_mul;

   assign op_b    = ALUSrcIn ? ExtendidoIn : RegData2In;
   assign is_mul  = (ALUControlIn == OP_MUL);
   assign ctrl_in = '{reg_write: RegWriteIn, memto_reg: MemtoRegIn, mem_write: MemWriteIn,
                      branch: BranchIn, write_reg: (RegDstIn ? rdIn : rtIn)};

   // Single-cycle ALU; unknown codes give zero
   always_comb begin
      alu_res = '0;
      case (ALUControlIn)
         OP_ADD:  alu_res = RegData1In + op_b;
         OP_SUB:  alu_res = RegData1In - op_b;
         OP_AND:  alu_res = RegData1In & op_b;
         OP_OR:   alu_res = RegData1In | op_b;
         OP_XOR:  alu_res = RegData1In ^ op_b;
         OP_SLT:  alu_res = {{(DATA_W-1){1'b0}}, ($signed(RegData1In) < $signed(op_b))};
         default: alu_res = '0;
      endcase
   end

   ex_mul_seq #(.DATA_W(DATA_W), .MUL_ITER(MUL_ITER)) u_mul (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (mul_start),
      .abort   (mul_abort),
      .a_in    (RegData1In),
      .b_in    (op_b),
      .done    (mul_done),
      .product (mul_prod)
   );

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   // Next-state: leave MUL on completion or flush
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (mul_start) state_nxt = ST_MUL;
         ST_MUL:  if (flush || mul_done) state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // FSM outputs; stall rises in the accept cycle so decode holds its next bundle
   always_comb begin
      mul_start  = (state == ST_IDLE) && in_valid && !flush && is_mul;
      alu_accept = (state == ST_IDLE) && in_valid && !flush && !is_mul;
      mul_abort  = (state == ST_MUL) && flush;
      stall      = rst_n && ((state == ST_MUL) || mul_start);
   end

   // Control bits and store data of the MUL in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ctrl_mul  <= '0;
         wdata_mul <= '0;
      end else if (mul_start) begin
         ctrl_mul  <= ctrl_in;
         wdata_mul <= RegData2In;
      end
   end

   // EX/MEM register: fields only load when a result is written, otherwise hold
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid    <= 1'b0;
         AluResultOut <= '0;
         WriteDataOut <= '0;
         WriteRegOut  <= '0;
         ZeroOut      <= 1'b0;
         RegWriteOut  <= 1'b0;
         MemtoRegOut  <= 1'b0;
         MemWriteOut  <= 1'b0;
         BranchOut    <= 1'b0;
      end else if (alu_accept) begin
         out_valid    <= 1'b1;
         AluResultOut <= alu_res;
         ZeroOut      <= (alu_res == '0);
         WriteDataOut <= RegData2In;
         {RegWriteOut, MemtoRegOut, MemWriteOut, BranchOut, WriteRegOut} <= ctrl_in;
      end else if (mul_done && !flush) begin
         out_valid    <= 1'b1;
         AluResultOut <= mul_prod;
         ZeroOut      <= (mul_prod == '0);
         WriteDataOut <= wdata_mul;
         {RegWriteOut, MemtoRegOut, MemWriteOut, BranchOut, WriteRegOut} <= ctrl_mul;
      end else begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_ex_stage_unit.sv
// Directed bench for ex_stage_unit with a cycle-level reference model.
module tb_ex_stage_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, flush;
   logic [31:0] rd1, rd2, ext;
   logic [4:0]  rt, rd;
   logic [5:0]  op;
   logic        alusrc, regwrite, memtoreg, memwrite, regdst, branch;
   logic        stall, out_valid, zero_o, rw_o, m2r_o, mw_o, br_o;
   logic [31:0] res_o, wdata_o;
   logic [4:0]  wreg_o;

   int n_tests = 0;
   int n_fail  = 0;

   ex_stage_unit dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
      .RegData1In(rd1), .RegData2In(rd2), .ExtendidoIn(ext),
      .rtIn(rt), .rdIn(rd), .ALUControlIn(op),
      .ALUSrcIn(alusrc), .RegWriteIn(regwrite), .MemtoRegIn(memtoreg),
      .MemWriteIn(memwrite), .RegDstIn(regdst), .BranchIn(branch),
      .flush(flush), .stall(stall), .out_valid(out_valid),
      .AluResultOut(res_o), .WriteDataOut(wdata_o), .WriteRegOut(wreg_o),
      .ZeroOut(zero_o), .RegWriteOut(rw_o), .MemtoRegOut(m2r_o),
      .MemWriteOut(mw_o), .BranchOut(br_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [31:0] f_alu(input logic [5:0] o, input logic [31:0] a, input logic [31:0] b);
      case (o)
         6'h20:   return a + b;
         6'h22:   return a - b;
         6'h24:   return a & b;
         6'h25:   return a | b;
         6'h26:   return a ^ b;
         6'h2A:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         6'h18:   return a * b;
         default: return 32'd0;
      endcase
   endfunction

   // Expected EX/MEM contents; ctrl = {regwrite, memtoreg, memwrite, branch}
   logic        m_valid;
   logic [31:0] m_res, m_wdata;
   logic [4:0]  m_wreg;
   logic [3:0]  m_ctrl;
   int          m_left;                 // cycles of MUL still to run, 0 when idle
   logic [31:0] p_res, p_wdata;
   logic [4:0]  p_wreg;
   logic [3:0]  p_ctrl;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_valid = 0; m_res = 0; m_wdata = 0; m_wreg = 0; m_ctrl = 0; m_left = 0;
      end else if (m_left > 0) begin
         if (flush) begin
            m_left = 0; m_valid = 0;
         end else if (m_left == 1) begin
            m_left = 0; m_valid = 1;
            m_res = p_res; m_wdata = p_wdata; m_wreg = p_wreg; m_ctrl = p_ctrl;
         end else begin
            m_left--; m_valid = 0;
         end
      end else if (in_valid && !flush) begin
         if (op == 6'h18) begin
            m_left  = 32; m_valid = 0;
            p_res   = f_alu(op, rd1, alusrc ? ext : rd2);
            p_wdata = rd2; p_wreg = regdst ? rd : rt;
            p_ctrl  = {regwrite, memtoreg, memwrite, branch};
         end else begin
            m_valid = 1;
            m_res   = f_alu(op, rd1, alusrc ? ext : rd2);
            m_wdata = rd2; m_wreg = regdst ? rd : rt;
            m_ctrl  = {regwrite, memtoreg, memwrite, branch};
         end
      end else begin
         m_valid = 0;
      end
   end

   // Compare DUT with model every cycle, mid-period
   always @(negedge clk) begin
      if (!rst_n) begin
         chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
         chk("rst_stall", {31'd0, stall}, 32'd0);
      end else begin
         chk("stall", {31'd0, stall},
             {31'd0, (m_left > 0) || (in_valid && op == 6'h18 && !flush)});
         chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
         if (m_valid) begin
            chk("result", res_o, m_res);
            chk("zero", {31'd0, zero_o}, {31'd0, m_res == 32'd0});
            chk("wdata", wdata_o, m_wdata);
            chk("wreg", {27'd0, wreg_o}, {27'd0, m_wreg});
            chk("ctrl", {28'd0, rw_o, m2r_o, mw_o, br_o}, {28'd0, m_ctrl});
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic drive(input logic v, input logic [5:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] e, input logic src, input logic [4:0] t, input logic [4:0] d,
                        input logic dst, input logic [3:0] c);
      in_valid = v; op = o; rd1 = a; rd2 = b; ext = e; alusrc = src;
      rt = t; rd = d; regdst = dst; {regwrite, memtoreg, memwrite, branch} = c;
   endtask

   task automatic tick();
      @(posedge clk); #2;
   endtask

   task automatic chk_all_zero(input string nm);
      chk({nm, "_valid"}, {31'd0, out_valid}, 32'd0);
      chk({nm, "_stall"}, {31'd0, stall}, 32'd0);
      chk({nm, "_res"}, res_o, 32'd0);
      chk({nm, "_wdata"}, wdata_o, 32'd0);
      chk({nm, "_misc"}, {22'd0, wreg_o, zero_o, rw_o, m2r_o, mw_o, br_o}, 32'd0);
   endtask

   initial begin
      int n;
      rst_n = 0; flush = 0;
      drive(0, 6'h00, 0, 0, 0, 0, 0, 0, 0, 4'h0);
      #1 chk_all_zero("reset0");
      tick(); tick();
      rst_n = 1;
      tick(); tick();

      // ADD overflow wraps, rd chosen
      drive(1, 6'h20, 32'h7FFF_FFFF, 32'd1, 0, 0, 5'd3, 5'd9, 1, 4'b1010);
      tick();
      chk("add_res", res_o, 32'h8000_0000);
      chk("add_zero", {31'd0, zero_o}, 32'd0);
      chk("add_wreg", {27'd0, wreg_o}, 32'd9);
      // SUB to zero, rt chosen
      drive(1, 6'h22, 32'd5, 32'd5, 0, 0, 5'd4, 5'd11, 0, 4'b1000);
      tick();
      chk("sub_res", res_o, 32'd0);
      chk("sub_zero", {31'd0, zero_o}, 32'd1);
      chk("sub_wreg", {27'd0, wreg_o}, 32'd4);
      // SLT signed with immediate
      drive(1, 6'h2A, 32'hFFFF_FFFF, 32'd100, 32'd2, 1, 5'd7, 5'd12, 0, 4'b0100);
      tick();
      chk("slt_res", res_o, 32'd1);
      chk("slt_wreg", {27'd0, wreg_o}, 32'd7);
      chk("slt_wdata", wdata_o, 32'd100);
      // Bubble: out_valid drops, fields hold
      in_valid = 0;
      tick();
      chk("idle_valid", {31'd0, out_valid}, 32'd0);
      chk("idle_hold", res_o, 32'd1);

      // Back-to-back single-cycle ops, including an unknown code
      drive(1, 6'h24, 32'hFF00_FF00, 32'h0F0F_0F0F, 0, 0, 5'd1, 5'd2, 1, 4'b0001);
      tick();
      chk("and_res", res_o, 32'h0F00_0F00);
      drive(1, 6'h25, 32'h1234_0000, 32'h0000_5678, 0, 0, 5'd5, 5'd6, 0, 4'b0010);
      tick();
      chk("or_res", res_o, 32'h1234_5678);
      drive(1, 6'h26, 32'hAAAA_AAAA, 32'd0, 32'hFFFF_FFFF, 1, 5'd8, 5'd10, 1, 4'b1111);
      tick();
      chk("xor_res", res_o, 32'h5555_5555);
      drive(1, 6'h3F, 32'd77, 32'd88, 0, 0, 5'd13, 5'd14, 1, 4'b1100);
      tick();
      chk("unk_res", res_o, 32'd0);
      chk("unk_ctrl", {28'd0, rw_o, m2r_o, mw_o, br_o}, 32'hC);
      in_valid = 0;
      tick();

      // MUL with an ADD held behind it
      drive(1, 6'h18, 32'd12345, 32'hFFFF_FFFF, 0, 0, 5'd15, 5'd16, 1, 4'b1000);
      #1 chk("mul_stall_comb", {31'd0, stall}, 32'd1);
      tick();
      drive(1, 6'h20, 32'd1, 32'd2, 0, 0, 5'd17, 5'd18, 0, 4'b1000);
      n = 0;
      while (!out_valid && n < 40) begin
         tick(); n++;
      end
      chk("mul_latency", n, 32);
      chk("mul_res", res_o, 32'hFFFF_CFC7);
      chk("mul_wreg", {27'd0, wreg_o}, 32'd16);
      chk("mul_stall_fall", {31'd0, stall}, 32'd0);
      tick();
      chk("held_add_res", res_o, 32'd3);
      chk("held_add_valid", {31'd0, out_valid}, 32'd1);
      in_valid = 0;
      tick();

      // Flush at iteration 10, then an ADD completes normally
      drive(1, 6'h18, 32'd7, 32'd9, 0, 0, 5'd1, 5'd1, 0, 4'b1000);
      tick();
      drive(1, 6'h20, 32'd40, 32'd2, 0, 0, 5'd2, 5'd3, 1, 4'b1000);
      repeat (9) tick();
      flush = 1;
      tick();
      flush = 0;
      chk("flush_mid_valid", {31'd0, out_valid}, 32'd0);
      chk("flush_mid_stall", {31'd0, stall}, 32'd0);
      tick();
      chk("post_flush_add", res_o, 32'd42);
      in_valid = 0;
      tick();

      // Flush coincident with the final iteration
      drive(1, 6'h18, 32'd3, 32'd5, 0, 0, 5'd1, 5'd1, 0, 4'b1000);
      tick();
      in_valid = 0;
      repeat (31) tick();
      flush = 1;
      tick();
      flush = 0;
      chk("flush_last_valid", {31'd0, out_valid}, 32'd0);
      chk("flush_last_res", res_o, 32'd42);
      tick(); tick();

      // Asynchronous reset in the middle of a MUL
      drive(1, 6'h18, 32'd9, 32'd9, 0, 0, 5'd1, 5'd1, 0, 4'b1000);
      tick();
      in_valid = 0;
      repeat (5) tick();
      #1 rst_n = 0;
      #1 chk_all_zero("reset_mid");
      tick();
      rst_n = 1;
      repeat (3) tick();
      chk("post_rst_valid", {31'd0, out_valid}, 32'd0);
      drive(1, 6'h22, 32'd10, 32'd3, 0, 0, 5'd4, 5'd5, 1, 4'b1000);
      tick();
      chk("post_rst_sub", res_o, 32'd7);
      in_valid = 0;
      tick(); tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
